i_bufds_bank: RTL and testbench
===============================

Name: i_bufds_bank

Overview:
- Parametrised multi-channel differential input bank.
- Each channel contains an I_BUF_DS primitive, a synchroniser, a glitch filter and an edge detector.
- Each channel also has a 2-bit mode counter that selects how the filtered input is combined with that channel's OE before a registered output.
- Used as the IO-test successor to single-pair buffer designs: it exercises N pairs, filtering and per-channel mode sequencing in one top.

Parameters:
- CHANNELS, 4, number of differential pairs (1..16).
- SYNC_STAGES, 2, synchroniser flops after the I_BUF_DS output (2..4).
- FILTER_LEN, 3, consecutive identical synchronised samples required to accept a new level (1..15).
- SLEW_RATE, "SLOW", passed to every I_BUF_DS.
- DELAY, 0, passed to every I_BUF_DS.

Ports:
- clk, input, 1, single system clock; also drives the C pin of every I_BUF_DS.
- rst_n, input, 1, reset, asynchronous, active-low.
- oe, input, CHANNELS, per-channel enable; drives I_BUF_DS OE and gates the channel logic.
- I_P, input, CHANNELS, differential positive pins.
- I_N, input, CHANNELS, differential negative pins.
- clr_mode, input, 1, synchronous clear of all mode counters.
- filtered, output, CHANNELS, debounced level per channel.
- rise, output, CHANNELS, 1-cycle pulse on an accepted 0->1 of filtered.
- mode, output, 2*CHANNELS, per-channel mode counter; channel i occupies bits [2i+1:2i].
- buffered_output, output, CHANNELS, registered combined result per channel.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All sync flops, filter counters, filtered, rise, mode and buffered_output clear to 0.
  - Release is synchronous to clk.
- Input gating: channel raw = I_BUF_DS.O AND oe[i]. When oe[i]=0 the channel sees constant 0.
- Synchroniser: raw passes through SYNC_STAGES flops; the last stage is s[i].
- Glitch filter, per channel:
  - Counter fc, width clog2(FILTER_LEN+1).
  - If s[i]==filtered[i]: fc <= 0.
  - Else if fc==FILTER_LEN-1: filtered[i] <= s[i] and fc <= 0.
  - Else: fc <= fc+1.
  - FILTER_LEN=1 means the change is accepted on the first differing sample.
  - Any agreeing sample restarts the count.
- Latency, steady pin change to filtered: SYNC_STAGES+FILTER_LEN clk edges (defaults: 5).
- rise[i] is registered and high for exactly one cycle, the cycle after filtered[i] goes 0->1.
- Mode counter, per channel:
  - clr_mode=1: mode <= 0. This has priority over increment.
  - Else if rise[i] and oe[i]: mode <= mode+1, wrapping 3->0.
  - Otherwise hold.
- Combine, registered one cycle after the filtered/mode values it uses:
  - mode 00: buffered_output = filtered.
  - mode 01: buffered_output = filtered & oe.
  - mode 10: buffered_output = filtered | oe.
  - mode 11: buffered_output = filtered ^ oe.
- oe deasserted mid-operation:
  - Input is forced to 0, so filtered falls after the filter latency.
  - Mode holds its value.
  - Output still follows the combine table using the live oe.
- Channels are fully independent; no cross-channel interaction except the shared clr_mode.
- Reset asserted mid-filter discards any partial count.

Test Plan:
- Reset: hold rst_n=0 while driving I_P=F, I_N=0, oe=F (all channels) -> filtered=0, rise=0, mode=0, buffered_output=0; remain 0 for 1 cycle after release.
- Step: channel 0 oe=1, I_P 0->1, I_N 1->0 held -> filtered[0]=1 exactly 5 cycles later; rise[0] pulses 1 cycle; mode[1:0]=01; buffered_output[0]=1 (filtered & oe).
- Glitch: channel 1, in FILTER_LEN=3 build, pulse I_P high for 2 cycles, then return -> filtered[1] stays 0, rise[1] never asserts, mode unchanged.
- Mode wrap: channel 2 oe=1, apply 4 clean rising edges spaced 10 cycles -> mode[5:4] sequence 01,10,11,00; in mode 11 with filtered=1, oe=1 -> buffered_output[2]=0.
- Clear priority: assert clr_mode in the same cycle rise[3]=1 with oe[3]=1 -> mode[7:6]=00 next cycle, not incremented.
- Disable: channel 0 in mode 10 with filtered=1, drop oe[0] -> filtered[0]=0 after 5 cycles; mode holds 10; buffered_output[0]=0 once filtered=0.

Source files
------------

// File: rtl/i_bufds_bank.sv
// Multi-channel differential input bank: per channel an I_BUF_DS, synchroniser,
// glitch filter, rise detector, 2-bit mode counter and registered combine stage.
module i_bufds_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter     SLEW_RATE   = "SLOW",
  parameter int DELAY       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   oe,
  input  logic [CHANNELS-1:0]   I_P,
  input  logic [CHANNELS-1:0]   I_N,
  input  logic                  clr_mode,
  output logic [CHANNELS-1:0]   filtered,
  output logic [CHANNELS-1:0]   rise,
  output logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   buffered_output
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FILTER_LEN - 1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic                   buf_o;
    logic                   raw;
    logic                   samp;
    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic [FCW-1:0]         fc_d, fc_q;
    logic                   filt_d, filt_q;
    logic                   filt_dly_d, filt_dly_q;
    logic                   rise_d, rise_q;
    logic [1:0]             mode_d, mode_q;
    logic                   out_d, out_q;

    I_BUF_DS #(
      .SLEW_RATE (SLEW_RATE),
      .DELAY     (DELAY)
    ) u_buf (
      .I_P (I_P[g]),
      .I_N (I_N[g]),
      .OE  (oe[g]),
      .C   (clk),
      .O   (buf_o)
    );

    assign raw  = buf_o & oe[g];
    assign samp = sync_q[SYNC_STAGES-1];

    // Next-state logic: sync chain, filter, rise delay, mode counter, combine.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw};
      fc_d   = fc_q;
      filt_d = filt_q;
      if (samp == filt_q) begin
        fc_d = '0;
      end else if (fc_q == FC_LAST) begin
        filt_d = samp;
        fc_d   = '0;
      end else begin
        fc_d = fc_q + FCW'(1);
      end

      // rise lags the accepted 0->1 of filtered by one cycle
      filt_dly_d = filt_q;
      rise_d     = filt_q & ~filt_dly_q;

      if (clr_mode) begin
        mode_d = 2'b00;
      end else if (rise_q && oe[g]) begin
        mode_d = mode_q + 2'b01;
      end else begin
        mode_d = mode_q;
      end

      case (mode_q)
        2'b00:   out_d = filt_q;
        2'b01:   out_d = filt_q & oe[g];
        2'b10:   out_d = filt_q | oe[g];
        2'b11:   out_d = filt_q ^ oe[g];
        default: out_d = 1'b0;
      endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q     <= '0;
        fc_q       <= '0;
        filt_q     <= 1'b0;
        filt_dly_q <= 1'b0;
        rise_q     <= 1'b0;
        mode_q     <= 2'b00;
        out_q      <= 1'b0;
      end else begin
        sync_q     <= sync_d;
        fc_q       <= fc_d;
        filt_q     <= filt_d;
        filt_dly_q <= filt_dly_d;
        rise_q     <= rise_d;
        mode_q     <= mode_d;
        out_q      <= out_d;
      end
    end

    assign filtered[g]         = filt_q;
    assign rise[g]             = rise_q;
    assign mode[2*g +: 2]      = mode_q;
    assign buffered_output[g]  = out_q;
  end

endmodule

// Behavioural differential input buffer: drives 1 only for a valid P=1/N=0 pair
// while enabled; the clock and timing attributes do not affect the logic level.
module I_BUF_DS #(
  parameter     SLEW_RATE = "SLOW",
  parameter int DELAY     = 0
) (
  input  logic I_P,
  input  logic I_N,
  input  logic OE,
  input  logic C,
  output logic O
);

  logic unused_cfg;

  assign O          = OE & I_P & ~I_N;
  assign unused_cfg = C ^ (DELAY != 0) ^ (SLEW_RATE == "FAST");

endmodule

// File: tb/tb_i_bufds_bank.sv
// Randomised scoreboard bench for i_bufds_bank: a window-based reference model
// queues expected outputs per clock edge, a monitor compares on the falling edge.
module tb_i_bufds_bank;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FL = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     oe, I_P, I_N;
  logic              clr_mode;
  logic [CH-1:0]     filtered, rise, buffered_output;
  logic [2*CH-1:0]   mode;

  always #5 clk = ~clk;

  i_bufds_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_LEN(FL), .SLEW_RATE("SLOW"), .DELAY(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .oe(oe), .I_P(I_P), .I_N(I_N), .clr_mode(clr_mode),
    .filtered(filtered), .rise(rise), .mode(mode), .buffered_output(buffered_output)
  );

  typedef struct packed {
    logic [CH-1:0]   f;
    logic [CH-1:0]   r;
    logic [2*CH-1:0] m;
    logic [CH-1:0]   o;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: accepted level, its previous value, rise, mode, output.
  logic [CH-1:0] m_f, m_fprev, m_rise, m_out;
  logic [1:0]    m_mode [CH];
  logic [CH-1:0] hist[$];   // hist[k] = input level presented k edges ago
  logic [CH-1:0] lvl;

  task automatic model_reset();
    m_f = '0; m_fprev = '0; m_rise = '0; m_out = '0;
    for (int c = 0; c < CH; c++) m_mode[c] = 2'b00;
    hist.delete();
    for (int k = 0; k < SS + FL; k++) hist.push_back('0);
  endtask

  // A level is accepted once the last FL samples leaving the synchroniser all disagree with it.
  task automatic model_edge();
    logic [CH-1:0] nf, nr, no;
    logic [1:0]    nm [CH];
    bit            agree;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_front(oe & I_P & ~I_N);
    if (hist.size() > SS + FL) void'(hist.pop_back());
    for (int c = 0; c < CH; c++) begin
      agree = 1'b0;
      for (int k = SS; k < SS + FL; k++) if (hist[k][c] == m_f[c]) agree = 1'b1;
      nf[c] = agree ? m_f[c] : ~m_f[c];
      nr[c] = m_f[c] & ~m_fprev[c];
      if (clr_mode)                nm[c] = 2'b00;
      else if (m_rise[c] && oe[c]) nm[c] = 2'(m_mode[c] + 2'd1);
      else                         nm[c] = m_mode[c];
      case (m_mode[c])
        2'd0:    no[c] = m_f[c];
        2'd1:    no[c] = m_f[c] & oe[c];
        2'd2:    no[c] = m_f[c] | oe[c];
        default: no[c] = m_f[c] ^ oe[c];
      endcase
    end
    m_fprev = m_f;
    m_f     = nf;
    m_rise  = nr;
    m_out   = no;
    for (int c = 0; c < CH; c++) m_mode[c] = nm[c];
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.f = m_f; e.r = m_rise; e.o = m_out;
    for (int c = 0; c < CH; c++) e.m[2*c +: 2] = m_mode[c];
    exp_q.push_back(e);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous assertion: the entry queued for the current cycle becomes all-zero.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
  endtask

  task automatic set_ch(input int c, input bit v);
    lvl[c] = v;
    I_P[c] = v;
    I_N[c] = ~v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("filtered",        32'(filtered),        32'(e.f));
      chk("rise",            32'(rise),            32'(e.r));
      chk("mode",            32'(mode),            32'(e.m));
      chk("buffered_output", 32'(buffered_output), 32'(e.o));
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0; clr_mode = 1'b0;
    oe = '1; I_P = '1; I_N = '0; lvl = '1;
    model_reset();
    steps(3);
    rst_n = 1'b1;
    steps(2);

    // All channels idle low and disabled.
    oe = '0; I_P = '0; I_N = '1; lvl = '0;
    steps(10);

    // Clean step on channel 0.
    oe[0] = 1'b1; set_ch(0, 1'b1);
    steps(12);

    // Two-cycle glitch on channel 1 must be rejected.
    oe[1] = 1'b1; set_ch(1, 1'b1);
    steps(2);
    set_ch(1, 1'b0);
    steps(10);

    // Four clean rising edges on channel 2 wrap its mode counter.
    oe[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ch(2, 1'b1); steps(10);
      set_ch(2, 1'b0); steps(10);
    end

    // clr_mode coincides with the rise pulse on channel 3.
    oe[3] = 1'b1; set_ch(3, 1'b1);
    for (int i = 0; i < 12; i++) begin
      clr_mode = m_rise[3];
      step();
    end
    clr_mode = 1'b0;
    set_ch(3, 1'b0);
    steps(6);

    // Channel 0 to mode 10 with filtered high, then disable it.
    set_ch(0, 1'b0); steps(10);
    set_ch(0, 1'b1); steps(10);
    oe[0] = 1'b0;
    steps(10);
    oe[0] = 1'b1;

    // Randomised traffic with occasional invalid pairs, oe toggles, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(7) == 0) set_ch(c, ~lvl[c]);
        else set_ch(c, lvl[c]);
        if ($urandom_range(31) == 0) I_N[c] = I_P[c];
        if ($urandom_range(63) == 0) oe[c] = ~oe[c];
      end
      clr_mode = ($urandom_range(39) == 0);
      if ($urandom_range(499) == 0) begin
        do_reset();
        steps(2);
        rst_n = 1'b1;
      end
      step();
    end
    clr_mode = 1'b0;

    budget = 5;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
